jpeg_coeff_decoder: RTL

Pipelined, parametrised successor to the combinational magnitude decoder in the entropy-decode path. It accepts a stream of JPEG (size category, additional bits) tokens over a valid/ready handshake and sign-extends each token to a signed coefficient. For DC tokens it adds the per-component DC predictor. Results are saturated to the output width and sent to the dequantiser over a second valid/ready handshake.

---
 rtl/jpeg_coeff_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jpeg_coeff_decoder.sv
// jpeg_coeff_decoder: two-stage pipeline turning JPEG (size, additional bits)
// tokens into signed coefficients. Stage 1 sign-extends the magnitude code;
// stage 2 adds the per-component DC predictor, saturates and registers the
// result for the dequantiser.
//
// Handshake (both ports): a beat transfers on a rising edge where valid and
// ready are both high. The producer holds valid and its payload stable until
// that edge; out_valid never drops while the output waits for out_ready.
module jpeg_coeff_decoder #(
    parameter int SIZE_WIDTH = 4,
    parameter int CODE_WIDTH = 12,
    parameter int OUT_WIDTH  = 12,
    parameter int NUM_COMP   = 3,
    localparam int CW        = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE_WIDTH-1:0] in_size,
    input  logic [CODE_WIDTH-1:0] in_code,
    input  logic                  in_is_dc,
    input  logic [CW-1:0]         in_comp,
    input  logic                  in_restart,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_coeff,
    output logic                  out_sat,
    output logic                  out_err
);

    // Extended value width: magnitude plus sign plus one guard bit.
    localparam int VW = CODE_WIDTH + 2;
    // Predictor-plus-difference width, wide enough that the sum never wraps.
    localparam int RW = OUT_WIDTH + CODE_WIDTH + 2;

    localparam logic signed [RW-1:0] MAX_R =
        signed'({{(RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}});
    localparam logic signed [RW-1:0] MIN_R = ~MAX_R;

    // Whole pipeline advances together; a full output register blocks it.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1 register contents
    logic                 s1_valid;
    logic signed [VW-1:0] s1_v;
    logic                 s1_is_dc;
    logic [CW-1:0]        s1_comp;
    logic                 s1_restart;
    logic                 s1_err;

    // DC predictors, one per colour component
    logic signed [OUT_WIDTH-1:0] pred [NUM_COMP];

    // Stage 1 combinational extend results
    logic [VW-1:0]        ext_mask;
    logic [VW-1:0]        ext_bits;
    logic signed [VW-1:0] ext_v;
    logic                 ext_err;

    // Sign-extend the JPEG magnitude code: a leading 0 marks a negative value.
    always_comb begin
        ext_mask = '0;
        ext_bits = '0;
        ext_v    = '0;
        ext_err  = 1'b0;
        if (32'(in_size) > CODE_WIDTH) begin
            ext_err = 1'b1;
        end else if (in_size != '0) begin
            ext_mask = (VW'(1) << in_size) - VW'(1);
            ext_bits = VW'(in_code) & ext_mask;
            // top bit of the field is the bit in mask but not in mask>>1
            if ((ext_bits & (ext_mask ^ (ext_mask >> 1))) != '0) begin
                ext_v = signed'(ext_bits);
            end else begin
                ext_v = signed'(ext_bits - ext_mask);
            end
        end
        if (in_is_dc && (32'(in_comp) >= NUM_COMP)) begin
            ext_err = 1'b1;
        end
    end

    // Stage 2 combinational predict/saturate results
    logic signed [OUT_WIDTH-1:0] pred_sel;
    logic signed [RW-1:0]        sum;
    logic [OUT_WIDTH-1:0]        st2_coeff;
    logic                        st2_sat;

    // Add the (possibly restart-cleared) predictor and clamp to the output range.
    always_comb begin
        pred_sel  = '0;
        st2_coeff = '0;
        st2_sat   = 1'b0;
        if (s1_is_dc && !s1_restart && !s1_err) begin
            for (int i = 0; i < NUM_COMP; i++) begin
                if (CW'(i) == s1_comp) begin
                    pred_sel = pred[i];
                end
            end
        end
        sum = RW'(pred_sel) + RW'(s1_v);
        if (s1_err) begin
            st2_coeff = '0;
        end else if (sum > MAX_R) begin
            st2_coeff = MAX_R[OUT_WIDTH-1:0];
            st2_sat   = 1'b1;
        end else if (sum < MIN_R) begin
            st2_coeff = MIN_R[OUT_WIDTH-1:0];
            st2_sat   = 1'b1;
        end else begin
            st2_coeff = sum[OUT_WIDTH-1:0];
        end
    end

    // Pipeline registers: stage 1 captures accepted tokens, stage 2 the results.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_v       <= '0;
            s1_is_dc   <= 1'b0;
            s1_comp    <= '0;
            s1_restart <= 1'b0;
            s1_err     <= 1'b0;
            out_valid  <= 1'b0;
            out_coeff  <= '0;
            out_sat    <= 1'b0;
            out_err    <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_v       <= ext_v;
                s1_is_dc   <= in_is_dc;
                s1_comp    <= in_comp;
                s1_restart <= in_restart;
                s1_err     <= ext_err;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_coeff <= st2_coeff;
                out_sat   <= st2_sat;
                out_err   <= s1_err;
            end
        end
    end

    // Predictor update as a token leaves stage 1; restart clears all but the
    // entry this token writes, so a restart DC token seeds its own component.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_COMP; i++) begin
                pred[i] <= '0;
            end
        end else if (en && s1_valid) begin
            for (int i = 0; i < NUM_COMP; i++) begin
                if (s1_is_dc && !s1_err && (CW'(i) == s1_comp)) begin
                    pred[i] <= signed'(st2_coeff);
                end else if (s1_restart) begin
                    pred[i] <= '0;
                end
            end
        end
    end

endmodule
